// File: rtl/perspective_projector_pkg.sv
// Shared state encoding and fixed-point helpers for the perspective projector.
package projector_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    SCALE  = 2'd2,
    OUTPUT = 2'd3
  } state_t;

  localparam int unsigned FIX_W = 16;
  localparam logic signed [FIX_W-1:0] MAX_POS = 16'sh7FFF;
  localparam logic signed [FIX_W-1:0] MIN_NEG = 16'sh8000;

  // Clamp a wide signed value into the signed range of a w-bit word.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                  input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/perspective_projector_divider.sv
// Restoring divider: 2*WIDTH-bit dividend over WIDTH-bit divisor, one quotient bit per cycle.
module serial_divider #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               start,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic [WIDTH-1:0]   quotient,
  output logic               overflow,
  output logic               done
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] low;
  logic [WIDTH-1:0] q;
  logic [CW-1:0]    cnt;
  logic             busy;
  logic             hi_ovf;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  always_comb begin
    shifted = {rem, low[WIDTH-1]};
    trial   = shifted - {1'b0, divisor};
  end

  // An upper dividend half >= divisor means the quotient cannot fit in WIDTH bits.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rem    <= '0;
      low    <= '0;
      q      <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      hi_ovf <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem    <= dividend[2*WIDTH-1:WIDTH];
        low    <= dividend[WIDTH-1:0];
        q      <= '0;
        cnt    <= '0;
        busy   <= 1'b1;
        hi_ovf <= (dividend[2*WIDTH-1:WIDTH] >= divisor);
      end else if (busy) begin
        rem <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        q   <= {q[WIDTH-2:0], ~trial[WIDTH]};
        low <= {low[WIDTH-2:0], 1'b0};
        cnt <= cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient = q;
  assign overflow = hi_ovf | q[WIDTH-1];

endmodule

// File: rtl/perspective_projector.sv
// Projects a sphere centre to screen space with near-plane culling and saturated outputs.
module perspective_projector
  import projector_pkg::*;
#(
  parameter int unsigned      WIDTH         = 16,
  parameter int unsigned      FRAC          = 8,
  parameter logic [WIDTH-1:0] FOCAL         = 16'h4000,
  parameter logic [WIDTH-1:0] SCREEN_CX     = 16'h5000,
  parameter logic [WIDTH-1:0] SCREEN_CY     = 16'h3C00,
  parameter logic [WIDTH-1:0] SPHERE_RADIUS = 16'h0200,
  parameter logic [WIDTH-1:0] NEAR_Z        = 16'h0080
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  input  logic [WIDTH-1:0] z_in,
  input  logic             data_valid_in,
  output logic             ready_out,
  input  logic             rasterizer_ready,
  output logic [WIDTH-1:0] center_x_out,
  output logic [WIDTH-1:0] center_y_out,
  output logic [WIDTH-1:0] depth_out,
  output logic [WIDTH-1:0] radius_out,
  output logic             data_valid_out,
  output logic             culled_out
);

  localparam logic [2*WIDTH-1:0] DIVIDEND = {{WIDTH{1'b0}}, FOCAL} << FRAC;
  localparam logic [WIDTH-1:0]   K_MAX    = {1'b0, {(WIDTH-1){1'b1}}};

  state_t                  state;
  logic signed [WIDTH-1:0] x_r, y_r, z_r, k_r;
  logic                    accept, cull, div_start;
  logic [WIDTH-1:0]        div_q;
  logic                    div_ovf, div_done;

  logic signed [2*WIDTH-1:0] px, py, pr;
  logic signed [63:0]        sx, sy, sr;
  logic [WIDTH-1:0]          cx_next, cy_next, r_next;

  assign ready_out = (state == IDLE);
  assign accept    = ready_out & data_valid_in;
  assign cull      = (signed'(z_in) <= signed'(NEAR_Z));
  assign div_start = accept & ~cull;

  serial_divider #(.WIDTH(WIDTH)) u_div (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .start    (div_start),
    .dividend (DIVIDEND),
    .divisor  (z_in),
    .quotient (div_q),
    .overflow (div_ovf),
    .done     (div_done)
  );

  // Products are formed at double width, shifted arithmetically, then widened for clamping.
  always_comb begin
    px      = (2*WIDTH)'(x_r) * (2*WIDTH)'(k_r);
    py      = (2*WIDTH)'(y_r) * (2*WIDTH)'(k_r);
    pr      = (2*WIDTH)'(signed'(SPHERE_RADIUS)) * (2*WIDTH)'(k_r);
    sx      = 64'(signed'(SCREEN_CX)) + 64'(px >>> FRAC);
    sy      = 64'(signed'(SCREEN_CY)) - 64'(py >>> FRAC);
    sr      = 64'(pr >>> FRAC);
    cx_next = WIDTH'(saturate(sx, WIDTH));
    cy_next = WIDTH'(saturate(sy, WIDTH));
    r_next  = WIDTH'(saturate(sr, WIDTH));
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state          <= IDLE;
      x_r            <= '0;
      y_r            <= '0;
      z_r            <= '0;
      k_r            <= '0;
      center_x_out   <= '0;
      center_y_out   <= '0;
      depth_out      <= '0;
      radius_out     <= '0;
      data_valid_out <= 1'b0;
      culled_out     <= 1'b0;
    end else begin
      culled_out <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (cull) begin
              culled_out <= 1'b1;
            end else begin
              x_r   <= signed'(x_in);
              y_r   <= signed'(y_in);
              z_r   <= signed'(z_in);
              state <= DIVIDE;
            end
          end
        end
        DIVIDE: begin
          if (div_done) begin
            k_r   <= div_ovf ? signed'(K_MAX) : signed'(div_q);
            state <= SCALE;
          end
        end
        SCALE: begin
          center_x_out   <= cx_next;
          center_y_out   <= cy_next;
          radius_out     <= r_next;
          depth_out      <= z_r;
          data_valid_out <= 1'b1;
          state          <= OUTPUT;
        end
        OUTPUT: begin
          if (rasterizer_ready) begin
            data_valid_out <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_perspective_projector.sv
// Self-checking bench for perspective_projector against an arithmetic reference model.
module tb_perspective_projector;

  localparam longint FOCAL_V = 64'h4000;
  localparam longint CX_V    = 64'h5000;
  localparam longint CY_V    = 64'h3C00;
  localparam longint R_V     = 64'h0200;
  localparam longint NEAR_V  = 64'h0080;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [15:0] x_in = '0, y_in = '0, z_in = '0;
  logic        data_valid_in = 1'b0;
  logic        rasterizer_ready = 1'b0;
  logic        ready_out, data_valid_out, culled_out;
  logic [15:0] center_x_out, center_y_out, depth_out, radius_out;

  int total = 0;
  int bad   = 0;

  always #5 clk_in = ~clk_in;

  perspective_projector #(
    .WIDTH(16), .FRAC(8), .FOCAL(16'h4000), .SCREEN_CX(16'h5000),
    .SCREEN_CY(16'h3C00), .SPHERE_RADIUS(16'h0200), .NEAR_Z(16'h0080)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .data_valid_in(data_valid_in), .ready_out(ready_out),
    .rasterizer_ready(rasterizer_ready), .center_x_out(center_x_out),
    .center_y_out(center_y_out), .depth_out(depth_out), .radius_out(radius_out),
    .data_valid_out(data_valid_out), .culled_out(culled_out)
  );

  function automatic logic [15:0] sat16(input longint v);
    longint c;
    c = v;
    if (c > 32767) c = 32767;
    if (c < -32768) c = -32768;
    return c[15:0];
  endfunction

  function automatic bit is_cull(input logic [15:0] z);
    return longint'($signed(z)) <= NEAR_V;
  endfunction

  // Screen position = centre + world * focal / depth, radius = R * focal / depth.
  function automatic void model(input logic [15:0] x, y, z,
                                output logic [15:0] ex, ey, ez, er);
    longint k, xs, ys;
    xs = longint'($signed(x));
    ys = longint'($signed(y));
    k  = (FOCAL_V * 256) / longint'(z);
    if (k > 32767) k = 32767;
    ex = sat16(CX_V + ((xs * k) >>> 8));
    ey = sat16(CY_V - ((ys * k) >>> 8));
    er = sat16((R_V * k) >>> 8);
    ez = z;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (ready_out !== 1'b1 && n < 100) begin
      @(posedge clk_in); #1; n++;
    end
    total++;
    if (ready_out !== 1'b1) begin
      bad++; $display("FAIL wait_ready: ready_out=%b want 1 (timeout)", ready_out);
    end
  endtask

  task automatic send(input logic [15:0] x, y, z);
    wait_ready();
    x_in = x; y_in = y; z_in = z; data_valid_in = 1'b1;
    @(posedge clk_in); #1;
    data_valid_in = 1'b0;
  endtask

  // Called just after the accepting edge; checks latency, result, hold, handshake.
  task automatic collect(input logic [15:0] x, y, z, input int hold);
    logic [15:0] ex, ey, ez, er;
    int lat = 0;
    model(x, y, z, ex, ey, ez, er);
    while (data_valid_out !== 1'b1 && lat < 60) begin
      @(posedge clk_in); #1; lat++;
    end
    total++;
    if (lat != 18) begin
      bad++; $display("FAIL latency: got %0d edges want 18", lat);
    end
    total++;
    if ({center_x_out, center_y_out, depth_out, radius_out} !== {ex, ey, ez, er}) begin
      bad++;
      $display("FAIL result x=%h y=%h z=%h: got cx=%h cy=%h d=%h r=%h want cx=%h cy=%h d=%h r=%h",
               x, y, z, center_x_out, center_y_out, depth_out, radius_out, ex, ey, ez, er);
    end
    for (int i = 0; i < hold; i++) begin
      data_valid_in = 1'b1; x_in = 16'($urandom); y_in = 16'($urandom); z_in = 16'h0300;
      @(posedge clk_in); #1;
      total++;
      if ({data_valid_out, ready_out, center_x_out, center_y_out, depth_out, radius_out}
          !== {1'b1, 1'b0, ex, ey, ez, er}) begin
        bad++;
        $display("FAIL hold cycle %0d: got v=%b rdy=%b cx=%h cy=%h d=%h r=%h want v=1 rdy=0 %h %h %h %h",
                 i, data_valid_out, ready_out, center_x_out, center_y_out, depth_out, radius_out,
                 ex, ey, ez, er);
      end
    end
    data_valid_in = 1'b0;
    rasterizer_ready = 1'b1;
    @(posedge clk_in); #1;
    rasterizer_ready = 1'b0;
    total++;
    if ({data_valid_out, ready_out} !== 2'b01) begin
      bad++; $display("FAIL handshake: got v=%b rdy=%b want v=0 rdy=1", data_valid_out, ready_out);
    end
  endtask

  task automatic run_txn(input logic [15:0] x, y, z, input int hold);
    send(x, y, z);
    if (is_cull(z)) begin
      total++;
      if ({culled_out, ready_out, data_valid_out} !== 3'b110) begin
        bad++;
        $display("FAIL cull z=%h: got cul=%b rdy=%b v=%b want 1 1 0", z, culled_out, ready_out, data_valid_out);
      end
      @(posedge clk_in); #1;
      total++;
      if ({culled_out, data_valid_out} !== 2'b00) begin
        bad++; $display("FAIL cull pulse: got cul=%b v=%b want 0 0", culled_out, data_valid_out);
      end
    end else begin
      collect(x, y, z, hold);
    end
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({ready_out, data_valid_out, culled_out, center_x_out, center_y_out, depth_out, radius_out}
        !== {1'b1, 1'b0, 1'b0, 64'h0}) begin
      bad++;
      $display("FAIL reset: got rdy=%b v=%b cul=%b cx=%h cy=%h d=%h r=%h want 1 0 0 zeros",
               ready_out, data_valid_out, culled_out, center_x_out, center_y_out, depth_out, radius_out);
    end
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b1;
  endtask

  task automatic test_directed();
    run_txn(16'h0100, 16'h0100, 16'h0200, 0);
    run_txn(16'hFF00, 16'h0000, 16'h0400, 0);
    run_txn(16'h6400, 16'h0000, 16'h0100, 0);
    run_txn(16'h0000, 16'h0000, 16'hFF00, 0);
  endtask

  task automatic test_cull_then_accept();
    wait_ready();
    x_in = 16'h1234; y_in = 16'h0042; z_in = 16'h0080; data_valid_in = 1'b1;
    @(posedge clk_in); #1;
    total++;
    if ({culled_out, ready_out, data_valid_out} !== 3'b110) begin
      bad++; $display("FAIL cull_eq: got cul=%b rdy=%b v=%b want 1 1 0", culled_out, ready_out, data_valid_out);
    end
    x_in = 16'h0100; y_in = 16'hFF00; z_in = 16'h0300;
    @(posedge clk_in); #1;
    data_valid_in = 1'b0;
    total++;
    if ({culled_out, ready_out} !== 2'b00) begin
      bad++; $display("FAIL cull_follow: got cul=%b rdy=%b want 0 0", culled_out, ready_out);
    end
    collect(16'h0100, 16'hFF00, 16'h0300, 0);
  endtask

  task automatic test_backpressure();
    run_txn(16'h0040, 16'hFFC0, 16'h0300, 20);
  endtask

  task automatic test_reset_mid();
    send(16'h0200, 16'h0100, 16'h0300);
    repeat (6) @(posedge clk_in);
    #1 rst_in = 1'b0;
    #1;
    total++;
    if ({ready_out, data_valid_out, culled_out, center_x_out, center_y_out, depth_out, radius_out}
        !== {1'b1, 1'b0, 1'b0, 64'h0}) begin
      bad++;
      $display("FAIL reset_mid: got rdy=%b v=%b cul=%b cx=%h cy=%h d=%h r=%h want 1 0 0 zeros",
               ready_out, data_valid_out, culled_out, center_x_out, center_y_out, depth_out, radius_out);
    end
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b1;
    run_txn(16'hFE80, 16'h0300, 16'h0500, 0);
  endtask

  task automatic test_back_to_back();
    logic [15:0] ex, ey, ez, er;
    int lat = 0;
    send(16'h0080, 16'h0080, 16'h0200);
    model(16'h0080, 16'h0080, 16'h0200, ex, ey, ez, er);
    while (data_valid_out !== 1'b1 && lat < 60) begin
      @(posedge clk_in); #1; lat++;
    end
    total++;
    if ({center_x_out, center_y_out, depth_out, radius_out} !== {ex, ey, ez, er}) begin
      bad++; $display("FAIL b2b first: got cx=%h cy=%h want %h %h", center_x_out, center_y_out, ex, ey);
    end
    x_in = 16'hFFF0; y_in = 16'h0010; z_in = 16'h0180; data_valid_in = 1'b1; rasterizer_ready = 1'b1;
    @(posedge clk_in); #1;
    rasterizer_ready = 1'b0;
    total++;
    if ({data_valid_out, ready_out} !== 2'b01) begin
      bad++; $display("FAIL b2b release: got v=%b rdy=%b want 0 1", data_valid_out, ready_out);
    end
    @(posedge clk_in); #1;
    data_valid_in = 1'b0;
    total++;
    if (ready_out !== 1'b0) begin
      bad++; $display("FAIL b2b accept: got rdy=%b want 0", ready_out);
    end
    collect(16'hFFF0, 16'h0010, 16'h0180, 0);
  endtask

  task automatic test_random();
    logic [15:0] x, y, z;
    for (int n = 0; n < 25; n++) begin
      x = 16'($urandom);
      y = (n % 2 == 0) ? 16'($urandom_range(0, 16'h0400)) : 16'($urandom);
      case ($urandom_range(0, 3))
        0:       z = 16'($urandom_range(0, 16'h0080)) | ((n % 3 == 0) ? 16'h8000 : 16'h0000);
        1:       z = 16'($urandom_range(16'h0081, 16'h0200));
        default: z = 16'($urandom_range(16'h0081, 16'h7FFF));
      endcase
      run_txn(x, y, z, int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_cull_then_accept();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
